// File: rtl/poly_sum_pkg.sv
// Shared defaults and FSM encoding for the polyphase FIR output summer.
// Also used by the bank instances and the filter top.
package poly_sum_pkg;

  localparam int M_DEFAULT              = 20;
  localparam int INTERNAL_WIDTH_DEFAULT = 35;
  localparam int OUTPUT_WIDTH_DEFAULT   = 16;
  localparam int SHIFT_DEFAULT          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SUM   = 2'd1,
    ST_ROUND = 2'd2,
    ST_SAT   = 2'd3
  } state_t;

endpackage

// File: rtl/poly_sum_round_sat.sv
// Combinational round-half-up shift of the accumulator, plus a separate clamp of
// the registered rounded value to the signed output range with a clip flag.
module round_sat #(
  parameter int AW           = 40,
  parameter int SHIFT        = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int RW           = AW + 1 - SHIFT
) (
  input  logic signed [AW-1:0]           i_acc,
  output logic signed [RW-1:0]           o_rnd,
  input  logic signed [RW-1:0]           i_rnd,
  output logic signed [OUTPUT_WIDTH-1:0] o_dout,
  output logic                           o_clip
);

  localparam logic signed [AW:0]   HALF  = (AW + 1)'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_V = RW'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

  logic signed [AW:0] w_sum;

  // One guard bit keeps the +half from wrapping; >>> makes ties round toward +inf.
  assign w_sum = $signed({i_acc[AW-1], i_acc}) + HALF;
  assign o_rnd = RW'(w_sum >>> SHIFT);

  always_comb begin
    // NOTE: every output gets a default before the branches, otherwise a latch is inferred.
    o_dout = i_rnd[OUTPUT_WIDTH-1:0];
    o_clip = 1'b0;
    if (i_rnd > MAX_V) begin
      o_dout = OUTPUT_WIDTH'(MAX_V);
      o_clip = 1'b1;
    end else if (i_rnd < MIN_V) begin
      o_dout = OUTPUT_WIDTH'(MIN_V);
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/poly_sum.sv
// Snapshots all bank partial sums once per output period, sums them serially
// with one adder, then rounds and saturates to a single valid-qualified sample.
module poly_sum
  import poly_sum_pkg::*;
#(
  parameter int M              = M_DEFAULT,
  parameter int INTERNAL_WIDTH = INTERNAL_WIDTH_DEFAULT,
  parameter int OUTPUT_WIDTH   = OUTPUT_WIDTH_DEFAULT,
  parameter int SHIFT          = SHIFT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_2mhz_pos_en,
  input  logic [M*INTERNAL_WIDTH-1:0]   bank_dout,
  output logic [OUTPUT_WIDTH-1:0]       dout,
  output logic                          dout_valid,
  output logic                          sat,
  output logic                          overrun
);

  localparam int AW   = INTERNAL_WIDTH + $clog2(M);
  localparam int RW   = AW + 1 - SHIFT;
  localparam int IDXW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  state_t r_state;
  state_t w_next;

  logic [M*INTERNAL_WIDTH-1:0]     r_snap;
  logic signed [AW-1:0]            r_acc;
  logic [IDXW-1:0]                 r_idx;
  logic signed [RW-1:0]            r_rnd;
  logic [OUTPUT_WIDTH-1:0]         r_dout;
  logic                            r_dout_valid;
  logic                            r_sat;
  logic                            r_overrun;

  logic signed [INTERNAL_WIDTH-1:0] w_bank;
  logic signed [AW-1:0]             w_bank_ext;
  logic signed [RW-1:0]             w_rnd;
  logic signed [OUTPUT_WIDTH-1:0]   w_clamped;
  logic                             w_clip;

  assign w_bank     = r_snap[r_idx*INTERNAL_WIDTH +: INTERNAL_WIDTH];
  assign w_bank_ext = AW'(w_bank);

  round_sat #(
    .AW           (AW),
    .SHIFT        (SHIFT),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .RW           (RW)
  ) u_round_sat (
    .i_acc  (r_acc),
    .o_rnd  (w_rnd),
    .i_rnd  (r_rnd),
    .o_dout (w_clamped),
    .o_clip (w_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (clk_2mhz_pos_en) w_next = ST_SUM;
      ST_SUM:   if (r_idx == LAST_IDX) w_next = ST_ROUND;
      ST_ROUND: w_next = ST_SAT;
      ST_SAT:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the snapshot is reset along with the rest; it is a plain register, not a RAM.
    if (rst) begin
      r_snap       <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_rnd        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
      if (clk_2mhz_pos_en && r_state != ST_IDLE) r_overrun <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (clk_2mhz_pos_en) begin
            r_snap <= bank_dout;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        ST_SUM: begin
          r_acc <= r_acc + w_bank_ext;
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
        ST_ROUND: r_rnd <= w_rnd;
        ST_SAT: begin
          r_dout       <= w_clamped;
          r_dout_valid <= 1'b1;
          r_sat        <= w_clip;
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sat        = r_sat;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_poly_sum.sv
// Directed bench for poly_sum at default parameters; expected samples are
// hand-computed from the round-half-up / saturate rules.
module tb_poly_sum;

  localparam int M  = 20;
  localparam int IW = 35;
  localparam int OW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_2mhz_pos_en;
  logic [M*IW-1:0]   bank_dout;
  logic [OW-1:0]     dout;
  logic              dout_valid;
  logic              sat;
  logic              overrun;

  int n_vec  = 0;
  int n_fail = 0;

  poly_sum dut (
    .clk             (clk),
    .rst             (rst),
    .clk_2mhz_pos_en (clk_2mhz_pos_en),
    .bank_dout       (bank_dout),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .sat             (sat),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint observed, input longint expected);
    n_vec++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input longint v);
    for (int k = 0; k < M; k++) bank_dout[k*IW +: IW] = IW'(v);
  endtask

  task automatic set_ramp(input longint step);
    for (int k = 0; k < M; k++) bank_dout[k*IW +: IW] = IW'(longint'(k) * step);
  endtask

  task automatic set_one(input longint v0);
    set_all(0);
    bank_dout[0 +: IW] = IW'(v0);
  endtask

  // Called #1 after an edge (the launch edge); latency counts edges from it.
  task automatic run_vec(input string tag, input longint exp_dout, input longint exp_sat);
    int n;
    clk_2mhz_pos_en = 1'b1;
    tick();
    clk_2mhz_pos_en = 1'b0;
    n = 1;
    while (!dout_valid && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 23);
    check({tag, "_dout"}, longint'($signed(dout)), exp_dout);
    check({tag, "_sat"}, longint'(sat), exp_sat);
  endtask

  initial begin
    int n_valid;
    longint seen_dout;

    rst = 1'b1;
    clk_2mhz_pos_en = 1'b0;
    bank_dout = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_dout", longint'(dout), 0);
    check("reset_valid", longint'(dout_valid), 0);
    check("reset_sat", longint'(sat), 0);
    check("reset_overrun", longint'(overrun), 0);

    // Back-to-back vectors: each start is exactly M+3 cycles after the previous one.
    set_all(0);                       run_vec("zeros", 0, 0);
    set_all(65536);                   run_vec("all_64k", 20, 0);
    set_ramp(65536);                  run_vec("ramp", 190, 0);
    set_one(32768);                   run_vec("rnd_p_half", 1, 0);
    set_one(32767);                   run_vec("rnd_p_below", 0, 0);
    set_one(-32768);                  run_vec("rnd_n_half", 0, 0);
    set_one(-32769);                  run_vec("rnd_n_below", -1, 0);
    set_all(longint'(1) << 30);       run_vec("sat_pos", 32767, 1);
    set_all(-(longint'(1) << 30));    run_vec("sat_neg", -32768, 1);
    set_all(107370905);               run_vec("no_clip_edge", 32767, 0);
    check("no_overrun_at_min_spacing", longint'(overrun), 0);

    // Second start 5 cycles into the first sum, with the banks changed.
    set_all(65536);
    clk_2mhz_pos_en = 1'b1;
    tick();
    clk_2mhz_pos_en = 1'b0;
    repeat (4) tick();
    set_all(0);
    clk_2mhz_pos_en = 1'b1;
    tick();
    clk_2mhz_pos_en = 1'b0;
    n_valid = 0;
    seen_dout = -99999;
    repeat (40) begin
      tick();
      if (dout_valid) begin
        n_valid++;
        seen_dout = longint'($signed(dout));
      end
    end
    check("overrun_flag", longint'(overrun), 1);
    check("overrun_valid_count", n_valid, 1);
    check("overrun_dout", seen_dout, 20);

    // Reset in the middle of SUM abandons the sum.
    set_ramp(65536);
    clk_2mhz_pos_en = 1'b1;
    tick();
    clk_2mhz_pos_en = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_valid = 0;
    repeat (30) begin
      if (dout_valid) n_valid++;
      tick();
    end
    check("midrst_valid_count", n_valid, 0);
    check("midrst_dout", longint'(dout), 0);
    check("midrst_overrun", longint'(overrun), 0);
    run_vec("after_rst", 190, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
